// File: rtl/mul_seq.sv
`default_nettype none
// mul_seq: shift-and-add multiply sequencer for an AH/AL accumulator pair and its ALU.
// The product lands in AH:AL a fixed 3+2*WIDTH+1 cycles after start is accepted.
module mul_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       al_lsb,
  input  logic       alu_carry,
  output logic [1:0] hs,
  output logic [1:0] ls,
  output logic       ah_inen,
  output logic       ah_reset,
  output logic       carry_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    XFER  = 3'd2,
    CLRH  = 3'd3,
    TEST  = 3'd4,
    SHIFT = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [1:0]       SH_LOAD = 2'b00;
  localparam logic [1:0]       SH_SHR  = 2'b10;
  localparam logic [1:0]       SH_HOLD = 2'b11;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      carry_q  <= 1'b0;
      ah_reset <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= LOAD;
        LOAD: state <= XFER;
        XFER: begin
          state    <= CLRH;
          ah_reset <= 1'b1;
        end
        CLRH: begin
          ah_reset <= 1'b0;
          cnt      <= '0;
          carry_q  <= 1'b0;
          state    <= TEST;
        end
        TEST: begin
          // Only an actual add may produce a carry into the next shift.
          carry_q <= al_lsb & alu_carry;
          state   <= SHIFT;
        end
        SHIFT: begin
          cnt   <= cnt + 1'b1;
          state <= (cnt == LAST) ? DONE : TEST;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    hs        = SH_HOLD;
    ls        = SH_HOLD;
    ah_inen   = 1'b0;
    carry_out = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      LOAD: begin
        hs      = SH_LOAD;
        ah_inen = 1'b1;
      end
      XFER: ls = SH_LOAD;
      TEST: if (al_lsb) hs = SH_LOAD;
      SHIFT: begin
        hs        = SH_SHR;
        ls        = SH_SHR;
        carry_out = carry_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Sequencer that runs a 4x4 unsigned shift-and-add multiply on the AH/AL accumulator pair and its ALU.
- Drives the accumulator's shift controls (hs, ls), input-select (ah_inen), AH clear (ah_reset) and carry-in (carry_out).
- Product ends up in AH:AL, with AH as the high nibble.
- Multiplicand sits on the ALU's B operand. ALU is fixed at AH+B. Multiplier is presented on the accumulator's ah_in by the host.

Parameters:
WIDTH, 4, operand width; number of multiply iterations
CNT_W, 3, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk        input   1  clock, rising edge
clr        input   1  asynchronous active-high reset
start      input   1  request a multiply; sampled only in IDLE
al_lsb     input   1  accumulator al_out[0], the current multiplier bit
alu_carry  input   1  ALU carry-out of AH+B
hs         output  2  AH shift control: 00 load, 01 shl, 10 shr, 11 hold
ls         output  2  AL shift control, same encoding
ah_inen    output  1  1 = AH loads ah_in, 0 = AH loads ALU result
ah_reset   output  1  AH clear pulse, registered, glitch-free
carry_out  output  1  latched add carry, fed to AH msb on shr
busy       output  1  high from first cycle after start accepted until DONE exits
done       output  1  one-cycle pulse in DONE state

Behaviour:
- Reset and clocking: clk, with reset clr, asynchronous, active-high. clr forces state=IDLE, cnt=0, carry latch=0, ah_reset=0. All outputs take IDLE values immediately.
- IDLE output values: hs=ls=11, ah_inen=0, carry_out=0, busy=0, done=0.
- Output timing: all outputs are decoded from registered state. Exception: hs in TEST also depends on al_lsb (Mealy).
- ah_reset is a flop set on entry to CLRH and cleared on exit.

States and transitions:
- IDLE: start=1 -> LOAD. Otherwise stay.
- LOAD: hs=00, ah_inen=1, ls=11, so AH <= ah_in (multiplier). Go to XFER.
- XFER: ls=00, hs=11, so AL <= AH. Go to CLRH.
- CLRH: ah_reset=1, hs=ls=11, so AH=0. Clear cnt and carry latch. Go to TEST.
- TEST:
  - al_lsb=1: hs=00, ah_inen=0 (AH <= AH+B); carry latch <= alu_carry.
  - al_lsb=0: hs=11; carry latch <= 0.
  - ls=11 in both cases. Go to SHIFT.
- SHIFT: hs=10, ls=10, carry_out=carry latch.
  - Effect: AH <= {carry, AH[3:1]} and AL <= {AH[0], AL[3:1]}.
  - cnt <= cnt+1.
  - If cnt==WIDTH-1 -> DONE, else -> TEST.
- DONE: done=1, hs=ls=11, busy=1. Go to IDLE.

Timing:
- Start sampled at edge E0. State sequence: LOAD at cycle 1, XFER 2, CLRH 3, TEST/SHIFT pairs at cycles 4-11, DONE 12.
- Product is valid in AH:AL from cycle 12 and is held until the next start.
- Fixed latency of 3+2*WIDTH+1 cycles, independent of operand values.

Boundary conditions:
- start while busy: ignored; no queuing.
- start held high across DONE: a new operation begins at the IDLE cycle after DONE. There is no back-to-back DONE->LOAD.
- carry_out is 0 in every state other than SHIFT.
- Carry latch is cleared in CLRH, so no carry leaks between operations.
- clr mid-operation: abort to IDLE. Accumulator contents are undefined to the host. done is not asserted.
- ah_reset must never be high in the same cycle as hs=00.

Test Plan:
- Reset: clr pulse in mid-cycle -> hs=ls=11, busy=0, done=0, ah_reset=0 asynchronously, no clock needed.
- Basic multiply: multiplier 4'hB on ah_in, B=4'hD, pulse start -> done exactly at cycle 12; AH=4'h8, AL=4'hF (143); busy high for cycles 1-12.
- Carry path: 4'hF x 4'hF -> AH=4'hE, AL=4'h1 (225). carry_out=1 in at least one SHIFT cycle.
- Zero: multiplier 4'h0, B=4'h9 -> hs never 00 in any TEST cycle; AH:AL=8'h00; latency still 12.
- Start while busy: second start pulse at cycle 5 -> ignored, single done pulse. Then start held high through DONE -> next LOAD occurs 2 cycles after DONE.
- Abort: clr at cycle 7 of 3x5 -> immediate IDLE, no done. Fresh 3x5 afterwards -> AH=4'h0, AL=4'hF.
